// File: rtl/fetch_unit_if.sv
// Fetch unit bus: IMEM read port plus the {pc,inst} handshake to decode.
// master = fetch unit side, slave = memory/decode side.
interface fetch_unit_if;
    logic        o_imem_ren;
    logic [31:0] o_imem_raddr;
    logic [31:0] i_imem_rdata;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_pc;
    logic [31:0] o_inst;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_misaligned;

    modport master (
        output o_imem_ren,
        output o_imem_raddr,
        input  i_imem_rdata,
        output o_valid,
        input  i_ready,
        output o_pc,
        output o_inst,
        input  i_redirect,
        input  i_redirect_pc,
        output o_misaligned
    );

    modport slave (
        input  o_imem_ren,
        input  o_imem_raddr,
        output i_imem_rdata,
        input  o_valid,
        output i_ready,
        input  o_pc,
        input  o_inst,
        output i_redirect,
        output i_redirect_pc,
        input  o_misaligned
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, 1-cycle IMEM reads, show-ahead {pc,inst} FIFO.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect halts fetch sticky.
module fetch_unit #(
    parameter logic [31:0] RESET_ADDR  = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic         clk,
    input  logic         i_rst,
    fetch_unit_if.master bus
);
    localparam int AW = $clog2(QUEUE_DEPTH);

    logic [31:0]   pc;
    logic [31:0]   req_pc;
    logic          inflight;
    logic          kill;
    logic          misaligned;
    logic [AW:0]   count;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [31:0]   q_pc   [QUEUE_DEPTH];
    logic [31:0]   q_inst [QUEUE_DEPTH];

    logic          issue;
    logic          push;
    logic          pop;
    logic          empty;
    logic [AW+1:0] used;
    logic [AW+1:0] cap;
    logic [31:0]   target;
    logic          target_bad;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign target     = bus.i_redirect_pc;
    assign target_bad = |bus.i_redirect_pc[1:0];
`else
    assign target     = {bus.i_redirect_pc[31:2], 2'b00};
    assign target_bad = 1'b0;
`endif

    // Credit counts the slot freed by a pop this cycle, so a full
    // pipeline still sustains one fetch per cycle without overflow.
    assign used  = (AW+2)'(count) + (AW+2)'(inflight);
    assign cap   = (AW+2)'(QUEUE_DEPTH) + (AW+2)'(pop);
    assign empty = (count == '0);

    assign issue = !i_rst && !bus.i_redirect && !misaligned
                   && (used < cap);
    assign push  = inflight && !kill && !bus.i_redirect;

    assign bus.o_valid = !empty && !bus.i_redirect && !i_rst
                         && !misaligned;
    assign pop = bus.o_valid && bus.i_ready;

    assign bus.o_imem_ren   = issue;
    assign bus.o_imem_raddr = pc;
    assign bus.o_pc         = q_pc[rd_ptr];
    assign bus.o_inst       = q_inst[rd_ptr];
    assign bus.o_misaligned = misaligned;

    // PC, request tracking and FIFO occupancy; reset beats redirect.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            pc         <= RESET_ADDR;
            req_pc     <= RESET_ADDR;
            inflight   <= 1'b0;
            kill       <= 1'b0;
            misaligned <= 1'b0;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
        end else if (bus.i_redirect) begin
            pc         <= target;
            inflight   <= 1'b0;
            kill       <= inflight;
            misaligned <= target_bad;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
        end else begin
            inflight <= issue;
            kill     <= 1'b0;
            if (issue) begin
                pc     <= pc + 32'd4;
                req_pc <= pc;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // FIFO storage: capture the returning word with its request PC.
    always_ff @(posedge clk) begin
        if (push && !i_rst) begin
            q_pc[wr_ptr]   <= req_pc;
            q_inst[wr_ptr] <= bus.i_imem_rdata;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random ready/redirect/reset,
// checked every cycle against a PC-stream model of the fetch behaviour.
module tb_fetch_unit;
    localparam logic [31:0] RESET_ADDR  = 32'h0000_0000;
    localparam int          QUEUE_DEPTH = 2;

    logic clk = 1'b0;
    logic i_rst;

    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_ADDR (RESET_ADDR),
        .QUEUE_DEPTH(QUEUE_DEPTH)
    ) dut (
        .clk  (clk),
        .i_rst(i_rst),
        .bus  (bus)
    );

    int checks = 0;
    int passes = 0;
    int hs_count = 0;

    function automatic logic [31:0] imem(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return {a[15:0], a[31:16]} ^ 32'hA5A5_0F0F;
    endfunction

    // Synchronous IMEM, one-cycle read latency.
    always @(posedge clk) begin
        if (bus.o_imem_ren) bus.i_imem_rdata <= imem(bus.o_imem_raddr);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: decode must see target, target+4, ... in order after each
    // reset/redirect; the head is frozen while stalled.
    logic [31:0] exp_pc    = RESET_ADDR;
    bit          halted    = 1'b0;
    bit          hold      = 1'b0;
    bit          prev_fl   = 1'b0;
    logic [31:0] hold_pc   = '0;
    logic [31:0] hold_inst = '0;

    always @(negedge clk) begin
        if (i_rst) begin
            chk("rst_ren", 32'(bus.o_imem_ren), 0);
            chk("rst_valid", 32'(bus.o_valid), 0);
            exp_pc  = RESET_ADDR;
            halted  = 1'b0;
            hold    = 1'b0;
            prev_fl = 1'b1;
        end else if (bus.i_redirect) begin
            chk("redir_ren", 32'(bus.o_imem_ren), 0);
            chk("redir_valid", 32'(bus.o_valid), 0);
`ifdef FETCH_MISALIGN_TRAP_EN
            if (bus.i_redirect_pc[1:0] != 2'b00) begin
                halted = 1'b1;
            end else begin
                halted = 1'b0;
                exp_pc = bus.i_redirect_pc;
            end
`else
            exp_pc = {bus.i_redirect_pc[31:2], 2'b00};
`endif
            hold    = 1'b0;
            prev_fl = 1'b1;
        end else begin
            if (prev_fl) chk("flush_valid", 32'(bus.o_valid), 0);
            prev_fl = 1'b0;
            chk("misaligned", 32'(bus.o_misaligned), 32'(halted));
            if (halted) begin
                chk("halt_ren", 32'(bus.o_imem_ren), 0);
                chk("halt_valid", 32'(bus.o_valid), 0);
            end
            if (hold) begin
                chk("hold_valid", 32'(bus.o_valid), 1);
                chk("hold_pc", bus.o_pc, hold_pc);
                chk("hold_inst", bus.o_inst, hold_inst);
            end
            if (bus.o_imem_ren) begin
                chk("raddr_align", 32'(bus.o_imem_raddr[1:0]), 0);
            end
            if (bus.o_valid && bus.i_ready) begin
                chk("hs_pc", bus.o_pc, exp_pc);
                chk("hs_inst", bus.o_inst, imem(exp_pc));
                exp_pc = exp_pc + 32'd4;
                hs_count++;
            end
            hold      = bus.o_valid && !bus.i_ready;
            hold_pc   = bus.o_pc;
            hold_inst = bus.o_inst;
        end
    end

    task automatic wait_hs(input string name, input logic [31:0] exp);
        bit found;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk);
            if (bus.o_valid && bus.i_ready) found = 1'b1;
            else tick();
        end
        if (found) begin
            chk(name, bus.o_pc, exp);
        end else begin
            checks++;
            $display("FAIL %s: no handshake within 20 cycles, expected pc %h",
                     name, exp);
        end
    endtask

    initial begin
        logic [31:0] t;
        i_rst             = 1'b1;
        bus.i_ready       = 1'b1;
        bus.i_redirect    = 1'b0;
        bus.i_redirect_pc = '0;
        repeat (3) tick();

        // 1: first fetch after reset
        i_rst = 1'b0;
        @(negedge clk);
        chk("t1_ren", 32'(bus.o_imem_ren), 1);
        chk("t1_raddr", bus.o_imem_raddr, 32'h0);
        tick();
        @(negedge clk);
        chk("t1_valid_c2", 32'(bus.o_valid), 0);
        tick();
        @(negedge clk);
        chk("t1_valid_c3", 32'(bus.o_valid), 1);
        chk("t1_pc", bus.o_pc, 32'h0);
        chk("t1_inst", bus.o_inst, 32'h0050_0093);

        // 2: gapless stream
        for (int i = 1; i <= 8; i++) begin
            tick();
            @(negedge clk);
            chk("t2_valid", 32'(bus.o_valid), 1);
            chk("t2_pc", bus.o_pc, 32'(4 * i));
        end

        // 3: stall five cycles then resume
        tick();
        bus.i_ready = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        chk("t3_ren_stop", 32'(bus.o_imem_ren), 0);
        chk("t3_head", bus.o_pc, 32'd36);
        tick();
        bus.i_ready = 1'b1;
        @(negedge clk);
        chk("t3_resume", bus.o_pc, 32'd36);

        // 4: redirect with a request in flight and FIFO occupied
        tick();
        bus.i_ready       = 1'b0;
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 32'h100;
        tick();
        bus.i_redirect = 1'b0;
        bus.i_ready    = 1'b1;
        wait_hs("t4_pc", 32'h100);

        // 5: misaligned redirect target
        tick();
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 32'h102;
        tick();
        bus.i_redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_mis", 32'(bus.o_misaligned), 1);
            chk("t5_ren", 32'(bus.o_imem_ren), 0);
            chk("t5_valid", 32'(bus.o_valid), 0);
            tick();
        end
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 32'h200;
        tick();
        bus.i_redirect = 1'b0;
        wait_hs("t5_pc", 32'h200);
        chk("t5_mis_clr", 32'(bus.o_misaligned), 0);
`else
        wait_hs("t5_pc", 32'h100);
        chk("t5_mis", 32'(bus.o_misaligned), 0);
`endif

        // 6: reset mid-stream with a request in flight
        tick();
        tick();
        @(negedge clk);
        chk("t6_ren", 32'(bus.o_imem_ren), 1);
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        @(negedge clk);
        chk("t6_valid", 32'(bus.o_valid), 0);
        wait_hs("t6_pc", RESET_ADDR);

        // 7: PC wraps past the top of the address space
        tick();
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 32'hFFFF_FFF8;
        tick();
        bus.i_redirect = 1'b0;
        wait_hs("t7_pc0", 32'hFFFF_FFF8);
        tick();
        @(negedge clk);
        chk("t7_pc1", bus.o_pc, 32'hFFFF_FFFC);
        tick();
        @(negedge clk);
        chk("t7_valid2", 32'(bus.o_valid), 1);
        chk("t7_pc2", bus.o_pc, 32'h0);

        // random ready / redirect / reset
        hs_count = 0;
        for (int n = 0; n < 3000; n++) begin
            tick();
            bus.i_ready    = ($urandom_range(0, 9) < 7);
            i_rst          = ($urandom_range(0, 199) == 0);
            bus.i_redirect = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0)
                t = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else
                t = 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            bus.i_redirect_pc = t;
        end
        tick();
        i_rst          = 1'b0;
        bus.i_redirect = 1'b0;
        @(negedge clk);
        chk("progress", 32'(hs_count > 300), 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
